// File: rtl/fetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: ITIM bus structs,
// FIFO entry layout and the fence sequencing states.
package fetch_buffer_wires;

  localparam int fbuf_depth_def = 4;
  localparam int fbuf_cnt_w     = $clog2(fbuf_depth_def) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fbuf_entry_type;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FDRAIN = 2'd1,
    FWAIT  = 2'd2
  } fbuf_state_type;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle between the prefetch buffer, the pipeline front end and the ITIM.
// master = fetch_buffer side, slave = surrounding pipeline/ITIM side.
interface fetch_buffer_if;
  import fetch_buffer_wires::*;

  logic        redirect_valid;
  logic        redirect_fence;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_data;
  logic        instr_ready;
  mem_in_type  itim_in;
  mem_out_type itim_out;

  modport master (
    input  redirect_valid, redirect_fence, redirect_pc, instr_ready, itim_out,
    output instr_valid, instr_pc, instr_data, itim_in
  );

  modport slave (
    output redirect_valid, redirect_fence, redirect_pc, instr_ready, itim_out,
    input  instr_valid, instr_pc, instr_data, itim_in
  );

endinterface

// File: rtl/fetch_buffer_fifo.sv
// Small FIFO of {pc, instr} pairs with a registered head; flush wins over
// any same-cycle push or pop.
module fetch_fifo
  import fetch_buffer_wires::*;
#(
  parameter int fbuf_depth = fbuf_depth_def,
  parameter int cnt_w      = fbuf_cnt_w
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  fbuf_entry_type       push_data,
  input  logic                 pop,
  output logic [cnt_w-1:0]     count,
  output logic                 head_valid,
  output fbuf_entry_type       head
);
  localparam int ptr_w = $clog2(fbuf_depth);

  fbuf_entry_type   mem_q [fbuf_depth];
  fbuf_entry_type   mem_d [fbuf_depth];
  logic [ptr_w-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  fbuf_entry_type   head_q, head_d;
  logic             push_eff, pop_eff;

  assign push_eff = push & ~flush;
  assign pop_eff  = pop & (count_q != '0) & ~flush;

  always_comb begin
    mem_d        = mem_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (flush) begin
      rd_d         = '0;
      wr_d         = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (push_eff) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + ptr_w'(1);
      end
      if (pop_eff) rd_d = rd_q + ptr_w'(1);
      count_d      = count_q + cnt_w'(push_eff) - cnt_w'(pop_eff);
      head_valid_d = (count_d != '0);
      // The pushed entry becomes head only when nothing older survives this cycle.
      if (push_eff && (count_q == cnt_w'(pop_eff))) head_d = push_data;
      else if (count_d != '0)                       head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count      = count_q;
  assign head_valid = head_valid_q;
  assign head       = head_q;

endmodule

// File: rtl/fetch_buffer.sv
// Sequential instruction prefetch in front of the ITIM: one request in
// flight, replies queued for decode, redirects with optional fence.i drain.
module fetch_buffer
  import fetch_buffer_wires::*;
#(
  parameter int          fbuf_depth = fbuf_depth_def,
  parameter logic [31:0] reset_pc   = 32'h0
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);
  localparam int             cnt_w   = $clog2(fbuf_depth) + 1;
  localparam logic [cnt_w:0] depth_c = (cnt_w + 1)'(fbuf_depth);

  fbuf_state_type state_q, state_d;
  logic [31:0]    pc_q, pc_d, req_pc_q, req_pc_d, mem_addr_q, mem_addr_d;
  logic           outstanding_q, outstanding_d, discard_q, discard_d;
  logic           mem_valid_q, mem_valid_d, mem_fence_q, mem_fence_d;
  logic           redir, ready, reply, push, issue;
  logic [cnt_w-1:0] count;
  logic [cnt_w:0]   occ;
  fbuf_entry_type push_data, head;
  logic           head_valid;

  assign redir     = bus.redirect_valid;
  assign ready     = bus.itim_out.mem_ready;
  assign reply     = outstanding_q & ready;
  assign push      = reply & ~discard_q & ~redir;
  assign push_data = '{pc: req_pc_q, instr: bus.itim_out.mem_rdata};
  // Occupancy includes the reply landing this cycle so a full FIFO never gets another request.
  assign occ       = {1'b0, count} + {{cnt_w{1'b0}}, push};
  assign issue     = (state_q == RUN) & ~redir & ~mem_valid_q
                   & (~outstanding_q | ready) & (occ < depth_c);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    mem_addr_d    = mem_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    mem_valid_d   = 1'b0;
    mem_fence_d   = 1'b0;

    case (state_q)
      FDRAIN: begin
        if (!outstanding_q) begin
          mem_valid_d = 1'b1;
          mem_fence_d = 1'b1;
          state_d     = FWAIT;
        end
      end
      FWAIT: begin
        if (ready) state_d = RUN;
      end
      default: ;
    endcase

    if (issue) begin
      mem_valid_d   = 1'b1;
      mem_addr_d    = pc_q;
      req_pc_d      = pc_q;
      pc_d          = pc_q + 32'd4;
      outstanding_d = 1'b1;
    end else if (reply) begin
      outstanding_d = 1'b0;
    end

    if (reply && discard_q) discard_d = 1'b0;

    if (redir) begin
      pc_d = bus.redirect_pc & ~32'd3;
      if (outstanding_q && !ready) discard_d = 1'b1;
      // An in-progress fence sequence is never restarted by a later redirect.
      if (state_q == RUN) state_d = bus.redirect_fence ? FDRAIN : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= reset_pc;
      req_pc_q      <= '0;
      mem_addr_q    <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_fence_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      mem_addr_q    <= mem_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      mem_valid_q   <= mem_valid_d;
      mem_fence_q   <= mem_fence_d;
    end
  end

  fetch_fifo #(
    .fbuf_depth (fbuf_depth),
    .cnt_w      (cnt_w)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redir),
    .push       (push),
    .push_data  (push_data),
    .pop        (bus.instr_ready),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.instr_valid = head_valid;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_data  = head.instr;
  assign bus.itim_in     = '{mem_valid: mem_valid_q, mem_fence: mem_fence_q, mem_instr: 1'b1,
                             mem_addr: mem_addr_q, mem_wdata: 32'h0, mem_wstrb: 4'h0};

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model, ITIM responder,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_buffer;
  import fetch_buffer_wires::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic clk = 1'b0;
  logic rst;
  fetch_buffer_if bus ();

  fetch_buffer #(.fbuf_depth(DEPTH), .reset_pc(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: state after the most recent clock edge
  logic [63:0] m_q[$];
  bit          m_out, m_disc, m_mv, m_mf;
  logic [31:0] m_pc, m_req, m_addr;
  int          m_st;             // 0 fetching, 1 draining for fence, 2 waiting on fence

  // ITIM responder
  bit          it_pend;
  int          it_cnt;
  logic [31:0] it_data;
  int          lat = 1;
  int          fence_lat = 64;

  // observation bookkeeping
  int          cyc = 0;
  int          n_req, n_fence, fence_cyc, cap_req_cyc;
  bit          cap_req_arm, cap_pop_arm, saw_req;
  logic [31:0] cap_req, cap_pop, last_addr;
  logic [63:0] pops[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.redirect_valid     = 1'b0;
    bus.redirect_fence     = 1'b0;
    bus.redirect_pc        = 32'h0;
    bus.instr_ready        = 1'b0;
    bus.itim_out.mem_ready = 1'b0;
    bus.itim_out.mem_rdata = 32'h0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = 0; m_disc = 0; m_mv = 0; m_mf = 0;
    m_pc = RPC; m_req = 0; m_addr = 0; m_st = 0;
    it_pend = 0; it_cnt = 0;
  endtask

  task automatic model_step(input bit rv, input bit rf, input logic [31:0] rpc,
                            input bit ir, input bit rdy, input logic [31:0] rd);
    bit reply, push, issue, fence_now, do_pop;
    int n_st;
    reply     = m_out && rdy;
    push      = reply && !m_disc && !rv;
    issue     = (m_st == 0) && !rv && !m_mv && (!m_out || rdy) && (m_q.size() + int'(push) < DEPTH);
    fence_now = (m_st == 1) && !m_out;
    if (rv) begin
      m_q.delete();
    end else begin
      do_pop = ir && (m_q.size() != 0);
      if (push) check("push_not_full", (m_q.size() - int'(do_pop)) < DEPTH, 1);
      if (do_pop) void'(m_q.pop_front());
      if (push) m_q.push_back({m_req, rd});
    end
    n_st = m_st;
    if (m_st == 0 && rv)      n_st = rf ? 1 : 0;
    else if (fence_now)       n_st = 2;
    else if (m_st == 2 && rdy) n_st = 0;
    if (reply && m_disc) m_disc = 0;
    if (rv && m_out && !rdy) m_disc = 1;
    if (issue) m_out = 1;
    else if (reply) m_out = 0;
    if (issue) begin
      m_req  = m_pc;
      m_addr = m_pc;
      m_pc   = m_pc + 32'd4;
    end
    if (rv) m_pc = rpc & ~32'd3;
    m_mv = issue || fence_now;
    m_mf = fence_now;
    m_st = n_st;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit rv, input bit rf, input logic [31:0] rpc, input bit ir);
    bit          rdy;
    logic [31:0] rd;
    check("instr_valid", bus.instr_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("instr_pc", bus.instr_pc, m_q[0][63:32]);
      check("instr_data", bus.instr_data, m_q[0][31:0]);
    end
    check("mem_valid", bus.itim_in.mem_valid, m_mv);
    check("mem_fence", bus.itim_in.mem_fence, m_mf);
    if (m_mv) check("mem_addr", bus.itim_in.mem_addr, m_addr);
    check("mem_instr", bus.itim_in.mem_instr, 1);

    if (bus.instr_valid && ir && !rv) begin
      pops.push_back({bus.instr_pc, bus.instr_data});
      if (cap_pop_arm) begin cap_pop = bus.instr_pc; cap_pop_arm = 0; end
    end

    rdy = 0;
    rd  = $urandom;
    saw_req = 0;
    if (it_pend) begin
      if (it_cnt == 0) begin rdy = 1; rd = it_data; it_pend = 0; end
      else it_cnt--;
    end
    if (bus.itim_in.mem_valid) begin
      check("one_outstanding", it_pend, 0);
      it_pend = 1;
      it_cnt  = (bus.itim_in.mem_fence ? fence_lat : lat) - 1;
      it_data = bus.itim_in.mem_fence ? $urandom : (bus.itim_in.mem_addr ^ 32'hA5A5A5A5);
      if (bus.itim_in.mem_fence) begin
        n_fence++;
        fence_cyc = cyc;
      end else begin
        n_req++;
        saw_req   = 1;
        last_addr = bus.itim_in.mem_addr;
        if (cap_req_arm) begin cap_req = bus.itim_in.mem_addr; cap_req_cyc = cyc; cap_req_arm = 0; end
      end
    end

    bus.redirect_valid     = rv;
    bus.redirect_fence     = rf;
    bus.redirect_pc        = rpc;
    bus.instr_ready        = ir;
    bus.itim_out.mem_ready = rdy;
    bus.itim_out.mem_rdata = rd;
    model_step(rv, rf, rpc, ir, rdy, rd);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_instr_valid"}, bus.instr_valid, 0);
    check({tag, "_instr_pc"}, bus.instr_pc, 0);
    check({tag, "_instr_data"}, bus.instr_data, 0);
    check({tag, "_mem_valid"}, bus.itim_in.mem_valid, 0);
    check({tag, "_mem_fence"}, bus.itim_in.mem_fence, 0);
    check({tag, "_mem_addr"}, bus.itim_in.mem_addr, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    drive_idle();
    model_reset();

    // T1: streaming with one-cycle ITIM
    do_reset();
    lat = 1;
    pops.delete();
    repeat (30) cycle(0, 0, 32'h0, 1);
    check("t1_pop_count", pops.size() >= 3, 1);
    check("t1_pop0", pops[0], {32'h100, 32'hA5A5A4A5});
    check("t1_pop1_pc", pops[1][63:32], 32'h104);
    check("t1_pop2_pc", pops[2][63:32], 32'h108);

    // T2: backpressure fills the FIFO, then drain resumes fetching
    do_reset();
    n_req = 0;
    repeat (40) cycle(0, 0, 32'h0, 0);
    check("t2_requests", n_req, 4);
    pops.delete();
    cap_req_arm = 1;
    cycle(0, 0, 32'h0, 1);
    check("t2_first_pop", pops[0][63:32], 32'h100);
    repeat (10) cycle(0, 0, 32'h0, 1);
    check("t2_resume_addr", cap_req, 32'h110);

    // T3: redirect while 0x108 is in flight with a slow ITIM
    do_reset();
    lat = 3;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 32'h0, 1);
      if (saw_req && last_addr == 32'h108) begin found = 1; break; end
    end
    check("t3_found_0x108", found, 1);
    cycle(1, 0, 32'h2003, 1);
    cap_req_arm = 1;
    cap_pop_arm = 1;
    repeat (20) cycle(0, 0, 32'h0, 1);
    check("t3_next_req", cap_req, 32'h2000);
    check("t3_first_pop", cap_pop, 32'h2000);

    // T4: redirect in the same cycle as mem_ready and instr_ready
    do_reset();
    lat = 1;
    repeat (6) cycle(0, 0, 32'h0, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (it_pend && it_cnt == 0) begin
        cycle(1, 0, 32'h3000, 1);
        found = 1;
        break;
      end
      cycle(0, 0, 32'h0, 1);
    end
    check("t4_fired", found, 1);
    check("t4_empty_after", bus.instr_valid, 0);
    cap_req_arm = 1;
    repeat (10) cycle(0, 0, 32'h0, 1);
    check("t4_next_req", cap_req, 32'h3000);

    // T5: fence.i with one request pending
    do_reset();
    lat = 2;
    fence_lat = 64;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 32'h0, 1);
      if (saw_req) begin found = 1; break; end
    end
    check("t5_req_pending", found, 1);
    cycle(1, 1, 32'h400, 1);
    n_fence = 0;
    cap_req_arm = 1;
    repeat (100) cycle(0, 0, 32'h0, 1);
    check("t5_fence_pulses", n_fence, 1);
    check("t5_next_req", cap_req, 32'h400);
    check("t5_fence_to_req", cap_req_cyc - fence_cyc, 66);

    // T6: asynchronous reset in the middle of the fence wait
    do_reset();
    lat = 1;
    repeat (3) cycle(0, 0, 32'h0, 0);
    cycle(1, 1, 32'h500, 0);
    n_fence = 0;
    repeat (12) cycle(0, 0, 32'h0, 0);
    check("t6_in_fwait", n_fence, 1);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("t6_async");
    drive_idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cap_req_arm = 1;
    repeat (10) cycle(0, 0, 32'h0, 1);
    check("t6_first_req", cap_req, RPC);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          rv, rf, ir;
      logic [31:0] rpc;
      lat       = $urandom_range(1, 4);
      fence_lat = $urandom_range(1, 12);
      rv  = ($urandom_range(0, 24) == 0);
      rf  = rv && ($urandom_range(0, 2) == 0);
      rpc = $urandom;
      ir  = ($urandom_range(0, 3) != 0);
      cycle(rv, rf, rpc, ir);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
